// File: rtl/fpu_pkg.sv
// Shared FP32 number conventions for the FPU datapath blocks: field widths,
// exponent constants, integer saturation limits and the operand class enum.
`timescale 1ns/1ps
package fpu_pkg;

    localparam int EXP_W      = 8;
    localparam int MAN_W      = 23;
    localparam int SIG_W      = 24;
    localparam int INT_W      = 32;

    localparam int BIAS       = 127;
    localparam int SHIFT_BASE = 150;

    localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_SAT,
        CLS_NAN
    } cls_e;

    // Sort an FP32 operand into the four float-to-int outcomes.
    // |x| < 0.5 and denormals flush to zero; e==158 is only representable
    // as the exact value -2^31, every other e>=158 saturates.
    function automatic cls_e classify(input logic s,
                                      input logic [EXP_W-1:0] e,
                                      input logic [MAN_W-1:0] m);
        cls_e c;
        if (e < EXP_W'(SHIFT_BASE - SIG_W))
            c = CLS_ZERO;
        else if (e == '1 && m != '0)
            c = CLS_NAN;
        else if (e > EXP_W'(BIAS + 31))
            c = CLS_SAT;
        else if (e == EXP_W'(BIAS + 31) && !(s && m == '0))
            c = CLS_SAT;
        else
            c = CLS_NORM;
        return c;
    endfunction

endpackage

// File: rtl/ftoi_pipe_if.sv
// Valid/ready stream bundle for the float-to-int converter: FP32 operand in,
// integer result plus saturation flag out.
`timescale 1ns/1ps
interface ftoi_pipe_if;
    import fpu_pkg::*;

    logic             x_valid;
    logic             x_ready;
    logic [INT_W-1:0] x_data;
    logic             y_valid;
    logic             y_ready;
    logic [INT_W-1:0] y_data;
    logic             y_ovf;

    modport master (
        output x_valid, x_data, y_ready,
        input  x_ready, y_valid, y_data, y_ovf
    );

    modport slave (
        input  x_valid, x_data, y_ready,
        output x_ready, y_valid, y_data, y_ovf
    );

endinterface

// File: rtl/rshift_sticky.sv
// Combinational 24-bit right shift by 0..31 that also reports the guard bit
// (first bit shifted out) and sticky bit (OR of all later shifted-out bits).
`timescale 1ns/1ps
module rshift_sticky (
    input  logic [23:0] din,
    input  logic [4:0]  sh,
    output logic [23:0] dout,
    output logic        g,
    output logic        s
);

    // 32 zero bits below the operand catch everything a shift of up to 31 drops
    logic [55:0] ext;

    assign ext  = {din, 32'd0} >> sh;
    assign dout = ext[55:32];
    assign g    = ext[31];
    assign s    = |ext[30:0];

endmodule

// File: rtl/ftoi_pipe.sv
// Three-stage FP32 -> int32 converter with round-to-nearest-even and
// saturation, behind an elastic valid/ready pipeline (one result per cycle).
`timescale 1ns/1ps
module ftoi_pipe
    import fpu_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    ftoi_pipe_if.slave bus
);

    localparam logic [4:0]       SH_LO  = 5'(SHIFT_BASE);
    localparam logic [EXP_W-1:0] E_BASE = EXP_W'(SHIFT_BASE);

    // Round-to-nearest-even on the truncated magnitude; never carries past
    // bit 23 of a right-shifted significand, so no re-saturation follows.
    function automatic logic [INT_W-1:0] round_rne(input logic [INT_W-1:0] mag,
                                                   input logic g,
                                                   input logic s);
        return mag + {{(INT_W-1){1'b0}}, g & (s | mag[0])};
    endfunction

    function automatic logic signed [INT_W-1:0] apply_sign(input logic sgn,
                                                           input logic [INT_W-1:0] mag);
        logic signed [INT_W-1:0] v;
        v = $signed(mag);
        return sgn ? -v : v;
    endfunction

    // Returns {ovf, data}: passes normal values, clamps out-of-range and NaN.
    function automatic logic [INT_W:0] saturate(input cls_e cls,
                                                input logic sgn,
                                                input logic signed [INT_W-1:0] val);
        logic [INT_W:0] r;
        case (cls)
            CLS_NORM: r = {1'b0, val};
            CLS_SAT:  r = {1'b1, (sgn ? INT_MIN : INT_MAX)};
            CLS_NAN:  r = {1'b1, INT_MAX};
            default:  r = '0;
        endcase
        return r;
    endfunction

    logic vld_p1, vld_p2, vld_p3;
    logic adv_p1, adv_p2, adv_p3;

    // Each stage moves when it is empty or the stage after it moves.
    assign adv_p3      = !vld_p3 || bus.y_ready;
    assign adv_p2      = !vld_p2 || adv_p3;
    assign adv_p1      = !vld_p1 || adv_p2;
    assign bus.x_ready = adv_p1;

    // ---- S1: classify and decode shift direction/amount ----
    logic             s_in;
    logic [EXP_W-1:0] e_in;
    logic [MAN_W-1:0] m_in;
    cls_e             cls_in;
    logic             lsh_in;
    logic [4:0]       amt_in;

    assign s_in   = bus.x_data[INT_W-1];
    assign e_in   = bus.x_data[MAN_W +: EXP_W];
    assign m_in   = bus.x_data[MAN_W-1:0];
    assign cls_in = classify(s_in, e_in, m_in);
    assign lsh_in = (e_in >= E_BASE);
    // Both distances are below 32, so modulo-32 arithmetic on e[4:0] is exact
    assign amt_in = lsh_in ? (e_in[4:0] - SH_LO) : (SH_LO - e_in[4:0]);

    cls_e             cls_p1;
    logic             sgn_p1;
    logic [SIG_W-1:0] sig_p1;
    logic             lsh_p1;
    logic [4:0]       amt_p1;

    // Stage 1 register: captures operand decode only on an input handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
            cls_p1 <= CLS_ZERO;
            sgn_p1 <= 1'b0;
            sig_p1 <= '0;
            lsh_p1 <= 1'b0;
            amt_p1 <= '0;
        end else if (adv_p1) begin
            vld_p1 <= bus.x_valid;
            if (bus.x_valid) begin
                cls_p1 <= cls_in;
                sgn_p1 <= s_in;
                sig_p1 <= {1'b1, m_in};
                lsh_p1 <= lsh_in;
                amt_p1 <= amt_in;
            end
        end
    end

    // ---- S2: align significand to the integer point ----
    logic [SIG_W-1:0] rsh_val;
    logic             rsh_g;
    logic             rsh_s;
    logic [INT_W-1:0] lsh_val;
    logic [INT_W-1:0] mag_in2;

    rshift_sticky u_rsh (
        .din  (sig_p1),
        .sh   (amt_p1),
        .dout (rsh_val),
        .g    (rsh_g),
        .s    (rsh_s)
    );

    assign lsh_val = {{(INT_W-SIG_W){1'b0}}, sig_p1} << amt_p1;
    assign mag_in2 = lsh_p1 ? lsh_val : {{(INT_W-SIG_W){1'b0}}, rsh_val};

    cls_e             cls_p2;
    logic             sgn_p2;
    logic [INT_W-1:0] mag_p2;
    logic             g_p2;
    logic             s_p2;

    // Stage 2 register: shifted magnitude with guard/sticky (zero for left shifts).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p2 <= 1'b0;
            cls_p2 <= CLS_ZERO;
            sgn_p2 <= 1'b0;
            mag_p2 <= '0;
            g_p2   <= 1'b0;
            s_p2   <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                cls_p2 <= cls_p1;
                sgn_p2 <= sgn_p1;
                mag_p2 <= mag_in2;
                g_p2   <= lsh_p1 ? 1'b0 : rsh_g;
                s_p2   <= lsh_p1 ? 1'b0 : rsh_s;
            end
        end
    end

    // ---- S3: round, negate, saturate ----
    logic [INT_W-1:0] mag_rnd;
    logic [INT_W:0]   fin;

    assign mag_rnd = round_rne(mag_p2, g_p2, s_p2);
    assign fin     = saturate(cls_p2, sgn_p2, apply_sign(sgn_p2, mag_rnd));

    logic signed [INT_W-1:0] y_data_p3;
    logic                    y_ovf_p3;

    // Stage 3 register: output holds while stalled, loads only with a valid item.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p3    <= 1'b0;
            y_data_p3 <= '0;
            y_ovf_p3  <= 1'b0;
        end else if (adv_p3) begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                y_data_p3 <= $signed(fin[INT_W-1:0]);
                y_ovf_p3  <= fin[INT_W];
            end
        end
    end

    assign bus.y_valid = vld_p3;
    assign bus.y_data  = y_data_p3;
    assign bus.y_ovf   = y_ovf_p3;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed testbench for ftoi_pipe: conversion values, rounding ties, range
// edges, specials, backpressure and mid-stream reset.
`timescale 1ns/1ps
module tb_ftoi_pipe;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ftoi_pipe_if bus ();

    ftoi_pipe dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.x_valid = 1'b0;
        bus.x_data  = '0;
        bus.y_ready = 1'b0;
        rstn        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got=%b want=0", bus.y_valid); end
        checks++; if (bus.y_data !== 32'h0) begin errors++; $display("FAIL reset_y_data got=%h want=00000000", bus.y_data); end
        checks++; if (bus.y_ovf !== 1'b0) begin errors++; $display("FAIL reset_y_ovf got=%b want=0", bus.y_ovf); end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        checks++; if (bus.x_ready !== 1'b1) begin errors++; $display("FAIL reset_x_ready got=%b want=1", bus.x_ready); end
        checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%b want=0", bus.y_valid); end
    endtask

    task automatic test_basic();
        logic [31:0] vin [4] = '{32'h3F80_0000, 32'h4020_0000, 32'h4060_0000, 32'hBFC0_0000};
        logic [31:0] exp [4] = '{32'd1, 32'd2, 32'd4, 32'hFFFF_FFFE};
        logic        exp_v;
        bus.y_ready = 1'b1;
        bus.x_valid = 1'b1;
        bus.x_data  = vin[0];
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 4) bus.x_data = vin[k];
            else       bus.x_valid = 1'b0;
            exp_v = (k >= 3 && k <= 6);
            checks++;
            if (bus.y_valid !== exp_v) begin
                errors++; $display("FAIL basic_valid cycle=%0d got=%b want=%b", k, bus.y_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (bus.y_data !== exp[k-3] || bus.y_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_data idx=%0d got=%h/%b want=%h/0", k-3, bus.y_data, bus.y_ovf, exp[k-3]);
                end
            end
        end
    endtask

    task automatic test_ties();
        logic [31:0] vin [6] = '{32'h3F00_0000, 32'h3F40_0000, 32'hC010_0000,
                                 32'h0000_0001, 32'hBF00_0000, 32'h3FC0_0000};
        logic [31:0] exp [6] = '{32'd0, 32'd1, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd2};
        int sent = 0;
        int got  = 0;
        bus.y_ready = 1'b1;
        bus.x_valid = 1'b1;
        bus.x_data  = vin[0];
        for (int c = 0; c < 20 && got < 6; c++) begin
            tick();
            if (bus.x_valid) sent++;
            if (sent < 6) bus.x_data = vin[sent];
            else          bus.x_valid = 1'b0;
            if (bus.y_valid) begin
                checks++;
                if (bus.y_data !== exp[got] || bus.y_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL ties idx=%0d in=%h got=%h/%b want=%h/0", got, vin[got], bus.y_data, bus.y_ovf, exp[got]);
                end
                got++;
            end
        end
        bus.x_valid = 1'b0;
        checks++; if (got != 6) begin errors++; $display("FAIL ties_count got=%0d want=6", got); end
    endtask

    task automatic test_range();
        logic [31:0] vin [5] = '{32'h4EFF_FFFF, 32'h4F00_0000, 32'hCF00_0000, 32'hCF00_0001, 32'h4E80_0000};
        logic [31:0] exp [5] = '{32'h7FFF_FF80, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        logic        eov [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int sent = 0;
        int got  = 0;
        bus.y_ready = 1'b1;
        bus.x_valid = 1'b1;
        bus.x_data  = vin[0];
        for (int c = 0; c < 20 && got < 5; c++) begin
            tick();
            if (bus.x_valid) sent++;
            if (sent < 5) bus.x_data = vin[sent];
            else          bus.x_valid = 1'b0;
            if (bus.y_valid) begin
                checks++;
                if (bus.y_data !== exp[got] || bus.y_ovf !== eov[got]) begin
                    errors++;
                    $display("FAIL range idx=%0d in=%h got=%h/%b want=%h/%b", got, vin[got], bus.y_data, bus.y_ovf, exp[got], eov[got]);
                end
                got++;
            end
        end
        bus.x_valid = 1'b0;
        checks++; if (got != 5) begin errors++; $display("FAIL range_count got=%0d want=5", got); end
    endtask

    task automatic test_specials();
        logic [31:0] vin [6] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                                 32'hFFC0_0000, 32'h8000_0000, 32'hFF00_0000};
        logic [31:0] exp [6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                                 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        logic        eov [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int sent = 0;
        int got  = 0;
        bus.y_ready = 1'b1;
        bus.x_valid = 1'b1;
        bus.x_data  = vin[0];
        for (int c = 0; c < 20 && got < 6; c++) begin
            tick();
            if (bus.x_valid) sent++;
            if (sent < 6) bus.x_data = vin[sent];
            else          bus.x_valid = 1'b0;
            if (bus.y_valid) begin
                checks++;
                if (bus.y_data !== exp[got] || bus.y_ovf !== eov[got]) begin
                    errors++;
                    $display("FAIL special idx=%0d in=%h got=%h/%b want=%h/%b", got, vin[got], bus.y_data, bus.y_ovf, exp[got], eov[got]);
                end
                got++;
            end
        end
        bus.x_valid = 1'b0;
        checks++; if (got != 6) begin errors++; $display("FAIL special_count got=%0d want=6", got); end
    endtask

    task automatic test_backpressure();
        logic [31:0] vin [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                                 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        int   sent = 0;
        int   rcv  = 0;
        logic exp_rdy;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            tick();
            bus.y_ready = (c >= 6);
            bus.x_valid = (sent < 8);
            bus.x_data  = (sent < 8) ? vin[sent] : 32'h0;
            #1;
            if (!bus.y_ready) begin
                exp_rdy = (sent < 3);
                checks++;
                if (bus.x_ready !== exp_rdy) begin
                    errors++; $display("FAIL bp_x_ready cycle=%0d got=%b want=%b", c, bus.x_ready, exp_rdy);
                end
            end
            if (rcv > 0) begin
                checks++;
                if (bus.y_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_gap cycle=%0d got_valid=%b want=1", c, bus.y_valid);
                end
            end
            if (bus.y_valid) begin
                checks++;
                if (bus.y_data !== 32'(rcv + 1) || bus.y_ovf !== 1'b0) begin
                    errors++; $display("FAIL bp_data cycle=%0d got=%h/%b want=%h/0", c, bus.y_data, bus.y_ovf, 32'(rcv + 1));
                end
            end
            if (bus.y_valid && bus.y_ready) rcv++;
            if (bus.x_valid && bus.x_ready) sent++;
        end
        tick();
        bus.x_valid = 1'b0;
        checks++; if (rcv != 8) begin errors++; $display("FAIL bp_count got=%0d want=8", rcv); end
        checks++; if (sent != 8) begin errors++; $display("FAIL bp_sent got=%0d want=8", sent); end
    endtask

    task automatic test_reset_mid();
        bus.y_ready = 1'b0;
        bus.x_valid = 1'b1;
        bus.x_data  = 32'h40A0_0000;
        tick();
        bus.x_data  = 32'h40C0_0000;
        tick();
        bus.x_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.y_valid !== 1'b1 || bus.y_data !== 32'd5) begin
            errors++; $display("FAIL rst_mid_pre got=%b/%h want=1/00000005", bus.y_valid, bus.y_data);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b want=0", bus.y_valid); end
        checks++; if (bus.y_data !== 32'h0) begin errors++; $display("FAIL rst_mid_data got=%h want=00000000", bus.y_data); end
        checks++; if (bus.y_ovf !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf got=%b want=0", bus.y_ovf); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn        = 1'b1;
        bus.y_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (bus.y_valid !== 1'b0) begin
                errors++; $display("FAIL rst_mid_stale cycle=%0d got_valid=%b data=%h want_valid=0", c, bus.y_valid, bus.y_data);
            end
            checks++;
            if (bus.x_ready !== 1'b1) begin
                errors++; $display("FAIL rst_mid_x_ready cycle=%0d got=%b want=1", c, bus.x_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_range();
        test_specials();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
